// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl : multi-cycle DIV/DIVU sequencer (radix-2 restoring divider + FSM)
//
// Accepts operands on a start pulse in IDLE and iterates one quotient bit per
// clock in BUSY. On completion it writes {hi = remainder, lo = quotient} and
// pulses result_valid for one cycle in DONE.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, sampled only in IDLE
//   signed_div   1 = DIV (two's complement), 0 = DIVU; sampled with start
//   annul        cancels a requested or in-flight operation
//   dividend     dividend operand, sampled with start
//   divisor      divisor operand, sampled with start
//   busy         high while iterating (pipeline stall request)
//   result_valid one-cycle pulse after hi/lo have been written
//   hi / lo      remainder / quotient of the last completed division
//
// Optional build macro:
//   DIV_ZERO_FAST_EN  a zero divisor skips BUSY and goes straight to DONE
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    // {rem[WIDTH:0], quot[WIDTH-1:0]}; quotient bits shift in as dividend
    // bits shift out into the remainder half.
    logic [2*WIDTH:0]   sr_reg, sr_next;
    logic [WIDTH-1:0]   dvsr_reg, dvsr_next;          // |divisor|
    logic [WIDTH-1:0]   dvnd_raw_reg, dvnd_raw_next;  // raw dividend for /0
    logic [CW-1:0]      count_reg, count_next;
    logic               sgn_reg, sgn_next;
    logic               dvnd_neg_reg, dvnd_neg_next;
    logic               dvsr_neg_reg, dvsr_neg_next;
    logic               zero_reg, zero_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    // One restoring step, computed from the current shift register.
    logic [2*WIDTH:0]   shifted;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH:0]   stepped;
    logic [WIDTH-1:0]   quot_res, rem_res;

    // Operand sign/magnitude at acceptance time.
    logic               in_dvnd_neg, in_dvsr_neg;
    logic [WIDTH-1:0]   in_dvnd_mag, in_dvsr_mag;

    always_comb begin
        shifted  = sr_reg << 1;
        // Extra guard bit so a negative trial is visible in the MSB.
        trial    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvsr_reg};
        stepped  = trial[WIDTH+1] ? shifted
                                  : {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        quot_res = stepped[WIDTH-1:0];
        // Remainder is always below |divisor|, so WIDTH bits suffice.
        rem_res  = stepped[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        in_dvnd_neg = signed_div & dividend[WIDTH-1];
        in_dvsr_neg = signed_div & divisor[WIDTH-1];
        // abs(most-negative) wraps back to itself, which is the correct
        // magnitude when read as unsigned.
        in_dvnd_mag = in_dvnd_neg ? (~dividend + 1'b1) : dividend;
        in_dvsr_mag = in_dvsr_neg ? (~divisor + 1'b1) : divisor;
    end

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        dvsr_next     = dvsr_reg;
        dvnd_raw_next = dvnd_raw_reg;
        count_next    = count_reg;
        sgn_next      = sgn_reg;
        dvnd_neg_next = dvnd_neg_reg;
        dvsr_neg_next = dvsr_neg_reg;
        zero_next     = zero_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;

        unique case (state_reg)
            IDLE: begin
                if (start && !annul) begin
                    sr_next       = {{(WIDTH+1){1'b0}}, in_dvnd_mag};
                    dvsr_next     = in_dvsr_mag;
                    dvnd_raw_next = dividend;
                    count_next    = '0;
                    sgn_next      = signed_div;
                    dvnd_neg_next = in_dvnd_neg;
                    dvsr_neg_next = in_dvsr_neg;
                    zero_next     = (divisor == '0);
                    state_next    = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0) begin
                        hi_next    = dividend;
                        lo_next    = '1;
                        state_next = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (annul) begin
                    state_next = IDLE;
                end else begin
                    sr_next    = stepped;
                    count_next = count_reg + 1'b1;
                    if (count_reg == CW'(WIDTH - 1)) begin
                        state_next = DONE;
                        if (zero_reg) begin
                            hi_next = dvnd_raw_reg;
                            lo_next = '1;
                        end else if (sgn_reg) begin
                            lo_next = (dvnd_neg_reg ^ dvsr_neg_reg)
                                      ? (~quot_res + 1'b1) : quot_res;
                            hi_next = dvnd_neg_reg ? (~rem_res + 1'b1) : rem_res;
                        end else begin
                            lo_next = quot_res;
                            hi_next = rem_res;
                        end
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sr_reg       <= '0;
            dvsr_reg     <= '0;
            dvnd_raw_reg <= '0;
            count_reg    <= '0;
            sgn_reg      <= 1'b0;
            dvnd_neg_reg <= 1'b0;
            dvsr_neg_reg <= 1'b0;
            zero_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            dvsr_reg     <= dvsr_next;
            dvnd_raw_reg <= dvnd_raw_next;
            count_reg    <= count_next;
            sgn_reg      <= sgn_next;
            dvnd_neg_reg <= dvnd_neg_next;
            dvsr_neg_reg <= dvsr_neg_next;
            zero_reg     <= zero_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
        end
    end

    assign busy         = (state_reg == BUSY);
    assign result_valid = (state_reg == DONE);
    assign hi           = hi_reg;
    assign lo           = lo_reg;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU instructions: signed/unsigned radix-2 restoring divider plus its control FSM.
- Sits beside the execute-stage ALU. Accepts operands on a start pulse and holds a busy/stall indication while iterating.
- Delivers {hi = remainder, lo = quotient} for the HI/LO registers, which feed back into the ALU's hi/lo inputs.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- annul  input  1  cancel in-flight or requested operation (exception/flush)
- dividend  input  WIDTH  sampled with start
- divisor  input  WIDTH  sampled with start
- busy  output  1  high while state is BUSY; drives pipeline stall request
- result_valid  output  1  one-cycle pulse, hi/lo freshly written
- hi  output  WIDTH  remainder of last completed division
- lo  output  WIDTH  quotient of last completed division

Behaviour:
- Reset (async): state = IDLE; busy = 0; result_valid = 0; hi = 0; lo = 0; internal shift/count registers = 0.
- States: IDLE, BUSY, DONE. All registered.
- IDLE:
  - start = 1 and annul = 0 at an edge E0: latch operand magnitudes, signed_div, the signs of dividend and divisor, and a divisor-zero flag; clear the counter; go to BUSY.
  - annul = 1 has priority over start: no acceptance.
- BUSY:
  - One restoring step per edge, on a 2*WIDTH+1-bit {rem, quot} shift register.
  - Step: shift left 1; trial = rem - |divisor|; if trial is non-negative, rem = trial and quotient LSB = 1, else quotient LSB = 0.
  - The counter increments per step. After WIDTH steps (edge E32 for WIDTH = 32), go to DONE and write hi/lo on that same edge.
  - start is ignored. busy = 1 throughout.
  - annul = 1 at any edge: go to IDLE; hi/lo unchanged; no result_valid.
- Sign correction, applied when writing hi/lo (signed_div = 1 only):
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes come from two's-complement abs; 0x80000000 abs = 0x80000000 (unsigned interpretation).
- DONE:
  - result_valid = 1 for exactly one cycle; next edge returns to IDLE unconditionally. annul in DONE has no effect; the result is already committed.
  - A start present in the DONE cycle is not accepted. The requester must re-present it in IDLE.
- Latency: accept at E0 → result_valid in the cycle following E(WIDTH) → IDLE after E(WIDTH+1). Back-to-back issue interval = WIDTH + 2 cycles.
- hi/lo hold their value between completions; only a DONE entry or reset changes them.
- Divide by zero (divisor = 0): hi = dividend (raw input value), lo = all-ones, in both signed and unsigned modes. No exception is raised. Timing depends on the optional feature.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: lo = 0x80000000, hi = 0. No trap.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: a divisor = 0 accepted at E0 goes directly IDLE → DONE. hi/lo are written at E0 with the divide-by-zero values; result_valid is asserted in the cycle after E0; busy never asserts.
- Undefined: divide by zero runs the full WIDTH-step BUSY sequence with normal latency. hi/lo are forced to the same divide-by-zero values at DONE entry. annul behaves as for any operation.

Test Plan:
- DIVU 100 / 7, start at E0 → busy for 32 cycles; result_valid in the cycle after E32; lo = 14, hi = 2; IDLE after E33.
- DIV -7 / 2 (0xFFFFFFF9 / 0x2) → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0; then DIVU 0xFFFFFFFF / 0x10 → lo = 0x0FFFFFFF, hi = 0xF.
- DIVU 0x1234 / 0 → hi = 0x1234, lo = 0xFFFFFFFF.
  - With DIV_ZERO_FAST_EN: result_valid in the cycle after E0; busy stays 0.
  - Without: result_valid after E32.
- Start 50 / 5; annul at E10 → IDLE at E10; result_valid never pulses; hi/lo keep prior values. Start and annul asserted together in IDLE → not accepted.
- rst asserted at E15 of an operation → busy, result_valid, hi and lo all 0 immediately. A new start after release completes normally at full latency.
